plab3_mem_wben_serializer: RTL
==============================

Name: plab3_mem_wben_serializer

Overview:
Write-back serializer on the cache-to-memory path, at the opposite end of the write-byte-enable (wben) path from the line-level wben decoder. It accepts one cache-line write carrying a per-byte mask of c_line_nbytes bits. It emits one narrow memory write per word whose 4-bit byte mask is nonzero, lowest word first, over val/rdy. The security domain is latched with the request and carried on every emitted beat.

Parameters:
p_word_idx_nbits, 2, log2 of words per line.
p_addr_nbits, 32, byte address width.
c_nwords, 1<<p_word_idx_nbits, words per line (local, not set from outside).
c_line_nbytes, 4*c_nwords, line bytes = input wben width (local).
c_line_nbits, 8*c_line_nbytes, line data width (local).

Ports:
clk  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
req_val  in  1  line write request valid.
req_rdy  out  1  block ready to accept a line.
req_domain  in  1  security domain of the request.
req_addr  in  p_addr_nbits  line address; low log2(c_line_nbytes) bits ignored.
req_data  in  c_line_nbits  line data, word i = bits [32i+31:32i].
req_wben  in  c_line_nbytes  byte mask, bit b covers byte b of the line.
out_val  out  1  word write valid.
out_rdy  in  1  memory accepts the word write.
out_domain  out  1  latched domain.
out_addr  out  p_addr_nbits  line base + 4*word index.
out_data  out  32  selected word.
out_wben  out  4  byte mask of the selected word.
out_idx  out  p_word_idx_nbits  selected word index.
out_last  out  1  this beat is the final beat of the line.

Behaviour:
- States: IDLE, SEND. Reset (reset_n low, asynchronous) forces IDLE and clears all latched registers to 0.
- Reset values: out_val=0, out_domain=0, out_addr=0, out_data=0, out_wben=0, out_idx=0, out_last=0. req_rdy=1 once reset_n is high.
- req_rdy=1 only in IDLE. A request is accepted when req_val&&req_rdy. No acceptance in SEND, including the cycle the last beat is accepted.
- On acceptance:
  - Latch domain, line base (low bits zeroed), data and mask.
  - If the mask is all zero: remain in IDLE, emit nothing, discard the request.
  - Otherwise go to SEND. First out_val rises the next cycle, so latency is 1 cycle.
- SEND:
  - out_val=1. out_idx = lowest word with a nonzero 4-bit mask nibble. out_wben = that nibble; out_data = that word. out_addr = base + (out_idx<<2).
  - out_last=1 iff no other nibble of the remaining mask is nonzero.
- Beat acceptance: out_val&&out_rdy clears the current nibble.
  - If the remaining mask is now zero, go to IDLE and clear the data/mask/domain registers to 0, so no stale secret data persists.
  - Otherwise the next lowest nonzero word is presented on the next cycle.
- Backpressure: while out_val&&!out_rdy, all out_* signals stay stable.
- Beats per line = popcount of nonzero nibbles, range 1..c_nwords. Words with a zero nibble are skipped, not sent with wben=0.
- Partial nibbles (e.g. 4'b0100) pass through unchanged.
- reset_n low mid-SEND: the line is aborted immediately and outputs take reset values; no resumption.
- Address arithmetic is modulo 2^p_addr_nbits; no carry into line-base bits beyond the word offset.
- Labels: control outputs (out_val, req_rdy, out_last, out_idx) are at level Ctrl; data/address/wben outputs are labelled by out_domain.

Decomposition:
- Shared package: state encoding (IDLE=0, SEND=1), c_nwords, c_line_nbytes, word-width constant 32.
- Sub-module plab3_mem_wben_encoder: the inverse of the wben decoder, purely combinational.
  - Inputs: c_line_nbytes-bit mask.
  - Outputs: lowest nonzero word index (p_word_idx_nbits), any-nonzero flag, and more-than-one-nonzero flag for out_last.

Test Plan:
- Full line: req_addr=0x1004, wben=0xFFFF, data words W0..W3 -> 4 beats, out_addr 0x1000/0x1004/0x1008/0x100C, out_wben=0xF each, out_last only on beat 4, req_rdy back to 1 the cycle after.
- Sparse: wben=0x0F00 -> single beat, out_idx=2, out_addr=base+8, out_data=W2, out_wben=0xF, out_last=1.
- Partial bytes: wben=0x4010 -> beats idx1 wben=0x1, then idx3 wben=0x4. Zero nibbles skipped.
- Zero mask: wben=0x0000 accepted -> out_val stays 0 and req_rdy stays 1.
- Backpressure: out_rdy low 3 cycles on beat 2 of a full line -> out_* held constant; req_val asserted during SEND is not accepted (req_rdy=0).
- Reset mid-line: reset_n low after beat 1 -> out_val=0 and out_data=0 asynchronously; after release req_rdy=1 and a new line (domain=1) sends correctly with out_domain=1.

Source files
------------

// File: rtl/plab3_mem_wben_serializer_pkg.sv
// Shared constants and FSM state encoding for the write-back wben serializer.
// The default geometry is four 32-bit words per line.
package plab3_mem_wben_serializer_pkg;

  localparam int c_word_nbits         = 32;
  localparam int c_wben_nbits         = 4;
  localparam int c_def_word_idx_nbits = 2;
  localparam int c_nwords             = 1 << c_def_word_idx_nbits;
  localparam int c_line_nbytes        = 4 * c_nwords;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/plab3_mem_wben_serializer_if.sv
// Line-write request and word-write beat channels, both val/rdy.
// The master drives requests and consumes beats; the slave is the serializer.
interface plab3_mem_wben_serializer_if
  import plab3_mem_wben_serializer_pkg::*;
#(
  parameter int p_word_idx_nbits = c_def_word_idx_nbits,
  parameter int p_addr_nbits     = 32
);
  localparam int lc_line_nbytes = 4 * (1 << p_word_idx_nbits);
  localparam int lc_line_nbits  = 8 * lc_line_nbytes;

  logic                        req_val;
  logic                        req_rdy;
  logic                        req_domain;
  logic [p_addr_nbits-1:0]     req_addr;
  logic [lc_line_nbits-1:0]    req_data;
  logic [lc_line_nbytes-1:0]   req_wben;

  logic                        out_val;
  logic                        out_rdy;
  logic                        out_domain;
  logic [p_addr_nbits-1:0]     out_addr;
  logic [c_word_nbits-1:0]     out_data;
  logic [c_wben_nbits-1:0]     out_wben;
  logic [p_word_idx_nbits-1:0] out_idx;
  logic                        out_last;

  modport master (
    output req_val, req_domain, req_addr, req_data, req_wben, out_rdy,
    input  req_rdy, out_val, out_domain, out_addr, out_data, out_wben, out_idx, out_last
  );

  modport slave (
    input  req_val, req_domain, req_addr, req_data, req_wben, out_rdy,
    output req_rdy, out_val, out_domain, out_addr, out_data, out_wben, out_idx, out_last
  );

endinterface

// File: rtl/plab3_mem_wben_encoder.sv
// Line byte mask to word-level summary: lowest word with a nonzero nibble,
// whether any nibble is nonzero, and whether more than one is.
module plab3_mem_wben_encoder
  import plab3_mem_wben_serializer_pkg::*;
#(
  parameter int p_word_idx_nbits = c_def_word_idx_nbits
) (
  input  logic [4*(1<<p_word_idx_nbits)-1:0] i_wben,
  output logic [p_word_idx_nbits-1:0]        o_idx,
  output logic                               o_any,
  output logic                               o_multi
);
  localparam int lc_nwords = 1 << p_word_idx_nbits;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_idx   = '0;
    o_any   = 1'b0;
    o_multi = 1'b0;
    for (int i = 0; i < lc_nwords; i++) begin
      if (i_wben[c_wben_nbits*i +: c_wben_nbits] != '0) begin
        if (o_any) begin
          o_multi = 1'b1;
        end else begin
          o_idx = p_word_idx_nbits'(i);
          o_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/plab3_mem_wben_serializer.sv
// Serializes one masked cache-line write into per-word memory writes, lowest
// word first, skipping words whose byte-mask nibble is zero.
module plab3_mem_wben_serializer
  import plab3_mem_wben_serializer_pkg::*;
#(
  parameter int p_word_idx_nbits = c_def_word_idx_nbits,
  parameter int p_addr_nbits     = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  plab3_mem_wben_serializer_if.slave    bus
);
  localparam int lc_nwords      = 1 << p_word_idx_nbits;
  localparam int lc_line_nbytes = 4 * lc_nwords;
  localparam int lc_line_nbits  = 8 * lc_line_nbytes;

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic                        r_domain;
  logic [p_addr_nbits-1:0]     r_base;
  logic [lc_line_nbits-1:0]    r_data;
  logic [lc_line_nbytes-1:0]   r_mask;

  logic [p_word_idx_nbits-1:0] w_idx;
  logic                        w_any;
  logic                        w_multi;
  logic                        w_send;
  logic                        w_accept;
  logic                        w_beat;
  logic                        w_line_done;
  logic [lc_line_nbytes-1:0]   w_mask_nxt;

  plab3_mem_wben_encoder #(
    .p_word_idx_nbits (p_word_idx_nbits)
  ) u_enc (
    .i_wben  (r_mask),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  // An all-zero mask is accepted but never latched, so nothing is emitted.
  assign w_send      = (r_state == SEND) && w_any;
  assign w_accept    = bus.req_val && (r_state == IDLE) && (|bus.req_wben);
  assign w_beat      = w_send && bus.out_rdy;
  assign w_line_done = w_beat && !w_multi;
  assign w_mask_nxt  = r_mask & ~(lc_line_nbytes'(4'hF) << {w_idx, 2'b00});

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = SEND;
      SEND:    if (w_line_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Everything is wiped when a line finishes so no secret data lingers in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_domain <= 1'b0;
      r_base   <= '0;
      r_data   <= '0;
      r_mask   <= '0;
    end else if (w_accept) begin
      r_domain <= bus.req_domain;
      r_base   <= bus.req_addr & ~p_addr_nbits'(lc_line_nbytes - 1);
      r_data   <= bus.req_data;
      r_mask   <= bus.req_wben;
    end else if (w_line_done) begin
      r_domain <= 1'b0;
      r_base   <= '0;
      r_data   <= '0;
      r_mask   <= '0;
    end else if (w_beat) begin
      r_mask   <= w_mask_nxt;
    end
  end

  assign bus.req_rdy    = (r_state == IDLE);
  assign bus.out_val    = w_send;
  assign bus.out_last   = w_send && !w_multi;
  assign bus.out_idx    = w_idx;
  assign bus.out_domain = r_domain;
  assign bus.out_addr   = r_base + (p_addr_nbits'(w_idx) << 2);
  assign bus.out_data   = r_data[c_word_nbits*int'(w_idx) +: c_word_nbits];
  assign bus.out_wben   = r_mask[c_wben_nbits*int'(w_idx) +: c_wben_nbits];

endmodule
